canvas_capture: RTL and testbench

Upstream drawing stage for the digit-recognition path. Maintains a 32x32 one-bit canvas that the user paints by moving a cursor with debounced button pulses and holding a pen switch. On submit it freezes the canvas and presents it, with a valid/ack handshake, as the 1024-bit raw image consumed by the dilation/flip stage. After the handshake it wipes itself with a row-by-row clear sweep.

---
 rtl/canvas_capture.sv | 143 ++++++++++++++
 tb/tb_canvas_capture.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/canvas_capture.sv
// canvas_capture: 32x32 one-bit drawing canvas with cursor, pen and clear sweep.
// On submit the canvas is frozen and offered downstream through a valid/ack handshake.
// After the ack it is optionally wiped one row per cycle.
module canvas_capture #(
  parameter bit          CLEAR_ON_ACK = 1'b1,
  parameter int unsigned START_X      = 16,
  parameter int unsigned START_Y      = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mv_up,
  input  logic          mv_down,
  input  logic          mv_left,
  input  logic          mv_right,
  input  logic          pen_down,
  input  logic          clear,
  input  logic          submit,
  input  logic          out_ack,
  output logic [1023:0] in_image,
  output logic          image_valid,
  output logic [4:0]    cursor_x,
  output logic [4:0]    cursor_y,
  output logic [10:0]   ink_count,
  output logic          busy
);

  typedef enum logic [1:0] {StDraw, StClear, StHold} state_e;

  state_e          state_q, state_d;
  logic [1023:0]   image_q, image_d;
  logic [4:0]      cx_q, cx_d;
  logic [4:0]      cy_q, cy_d;
  logic [10:0]     ink_q, ink_d;
  logic [4:0]      row_q, row_d;
  logic            valid_q, valid_d;
  logic            busy_q, busy_d;

  logic [9:0]      pix_idx;
  logic [4:0]      mv_x, mv_y;

  // One saturating step; opposite pulses cancel.
  function automatic logic [4:0] sat_step(input logic [4:0] p, input logic inc,
                                          input logic dec);
    logic [4:0] r;
    r = p;
    if (inc && !dec && p != 5'd31) r = p + 5'd1;
    if (dec && !inc && p != 5'd0)  r = p - 5'd1;
    return r;
  endfunction

  // Pixel (x,y) lives at bit y*32+x, i.e. the concatenation {y, x}.
  assign pix_idx = {cy_q, cx_q};
  assign mv_x    = sat_step(cx_q, mv_right, mv_left);
  assign mv_y    = sat_step(cy_q, mv_down, mv_up);

  // Next-state logic for the FSM, canvas, cursor and counters.
  always_comb begin
    state_d = state_q;
    image_d = image_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    ink_d   = ink_q;
    row_d   = row_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    unique case (state_q)
      StDraw: begin
        if (clear) begin
          state_d = StClear;
          row_d   = 5'd0;
          ink_d   = 11'd0;
          busy_d  = 1'b1;
        end else if (submit && ink_q != 11'd0) begin
          state_d = StHold;
          valid_d = 1'b1;
        end else begin
          // Paint uses the pre-move cursor; only 0->1 transitions count as ink.
          if (pen_down && !image_q[pix_idx]) begin
            image_d[pix_idx] = 1'b1;
            ink_d            = ink_q + 11'd1;
          end
          cx_d = mv_x;
          cy_d = mv_y;
        end
      end
      StClear: begin
        image_d[{row_q, 5'd0} +: 32] = 32'd0;
        row_d = row_q + 5'd1;
        if (row_q == 5'd31) begin
          state_d = StDraw;
          busy_d  = 1'b0;
        end
      end
      StHold: begin
        cx_d = mv_x;
        cy_d = mv_y;
        if (out_ack) begin
          valid_d = 1'b0;
          if (CLEAR_ON_ACK) begin
            state_d = StClear;
            row_d   = 5'd0;
            ink_d   = 11'd0;
            busy_d  = 1'b1;
          end else begin
            state_d = StDraw;
          end
        end
      end
      default: state_d = StDraw;
    endcase
  end

  // State registers with synchronous reset; the whole canvas is zeroed in the reset cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StDraw;
      image_q <= '0;
      cx_q    <= 5'(START_X);
      cy_q    <= 5'(START_Y);
      ink_q   <= 11'd0;
      row_q   <= 5'd0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      image_q <= image_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      ink_q   <= ink_d;
      row_q   <= row_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign in_image    = image_q;
  assign image_valid = valid_q;
  assign cursor_x    = cx_q;
  assign cursor_y    = cy_q;
  assign ink_count   = ink_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_canvas_capture.sv
// Bench for canvas_capture: vector table, directed corner sequences and random
// stimulus checked against a pixel-array model of the drawing rules.
module tb_canvas_capture;

  logic          clk;
  logic          rst;
  logic          mv_up, mv_down, mv_left, mv_right;
  logic          pen_down, clear, submit, out_ack;
  logic [1023:0] in_image;
  logic          image_valid;
  logic [4:0]    cursor_x, cursor_y;
  logic [10:0]   ink_count;
  logic          busy;

  int n_tests = 0;
  int n_fail  = 0;

  canvas_capture #(
    .CLEAR_ON_ACK(1'b1),
    .START_X     (16),
    .START_Y     (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mv_up      (mv_up),
    .mv_down    (mv_down),
    .mv_left    (mv_left),
    .mv_right   (mv_right),
    .pen_down   (pen_down),
    .clear      (clear),
    .submit     (submit),
    .out_ack    (out_ack),
    .in_image   (in_image),
    .image_valid(image_valid),
    .cursor_x   (cursor_x),
    .cursor_y   (cursor_y),
    .ink_count  (ink_count),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: mode 0 = drawing, 1 = wiping, 2 = holding.
  logic [1023:0] m_img;
  int            m_x, m_y, m_mode, m_row;

  function automatic int clamp31(input int v);
    if (v < 0) return 0;
    if (v > 31) return 31;
    return v;
  endfunction

  task automatic model_step(input logic [7:0] v, input bit r);
    int dx, dy;
    dx = int'(v[4]) - int'(v[5]);
    dy = int'(v[6]) - int'(v[7]);
    if (r) begin
      m_img = '0; m_x = 16; m_y = 16; m_mode = 0; m_row = 0;
    end else if (m_mode == 0) begin
      if (v[2]) begin
        m_mode = 1; m_row = 0;
      end else if (v[1] && $countones(m_img) != 0) begin
        m_mode = 2;
      end else begin
        if (v[3]) m_img[m_y * 32 + m_x] = 1'b1;
        m_x = clamp31(m_x + dx);
        m_y = clamp31(m_y + dy);
      end
    end else if (m_mode == 1) begin
      m_img[m_row * 32 +: 32] = 32'd0;
      m_row++;
      if (m_row == 32) m_mode = 0;
    end else begin
      m_x = clamp31(m_x + dx);
      m_y = clamp31(m_y + dy);
      if (v[0]) begin
        m_mode = 1; m_row = 0;
      end
    end
  endtask

  task automatic chk(input string nm, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_img(input string nm, input logic [1023:0] act, input logic [1023:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_model(input string nm);
    chk_img({nm, ".img"}, in_image, m_img);
    chk({nm, ".x"}, cursor_x, m_x);
    chk({nm, ".y"}, cursor_y, m_y);
    chk({nm, ".ink"}, ink_count, (m_mode == 1) ? 0 : $countones(m_img));
    chk({nm, ".valid"}, image_valid, m_mode == 2);
    chk({nm, ".busy"}, busy, m_mode == 1);
  endtask

  // Vector bit order: {up, down, left, right, pen, clear, submit, ack}.
  task automatic step(input logic [7:0] v, input bit r);
    {mv_up, mv_down, mv_left, mv_right, pen_down, clear, submit, out_ack} = v;
    rst = r;
    model_step(v, r);
    @(posedge clk);
    #1;
  endtask

  localparam logic [7:0] VUp = 8'h80, VDown = 8'h40, VLeft = 8'h20, VRight = 8'h10;
  localparam logic [7:0] VPen = 8'h08, VClr = 8'h04, VSub = 8'h02, VAck = 8'h01;

  typedef struct {
    logic [7:0] vin;
    int         ex, ey, eink;
    bit         ev, eb;
  } vec_t;

  vec_t          tbl[10];
  logic [1023:0] snap;

  initial begin
    tbl[0] = '{VRight | VPen, 17, 16, 1, 0, 0};
    tbl[1] = '{VPen,          17, 16, 2, 0, 0};
    tbl[2] = '{VPen,          17, 16, 2, 0, 0};
    tbl[3] = '{VUp,           17, 15, 2, 0, 0};
    tbl[4] = '{VLeft | VRight, 17, 15, 2, 0, 0};
    tbl[5] = '{VUp | VDown,   17, 15, 2, 0, 0};
    tbl[6] = '{VSub,          17, 15, 2, 1, 0};
    tbl[7] = '{VPen | VLeft,  16, 15, 2, 1, 0};
    tbl[8] = '{VSub | VClr,   16, 15, 2, 1, 0};
    tbl[9] = '{VAck,          16, 15, 0, 0, 1};

    // Reset state.
    step(8'h00, 1'b1);
    chk_img("rst.img", in_image, '0);
    chk("rst.x", cursor_x, 16);
    chk("rst.y", cursor_y, 16);
    chk("rst.ink", ink_count, 0);
    chk("rst.valid", image_valid, 0);
    chk("rst.busy", busy, 0);

    // Paint at (16,16) while moving right, then at (17,16).
    step(VPen | VRight, 1'b0);
    step(VPen, 1'b0);
    chk("paint.b528", in_image[528], 1);
    chk("paint.b529", in_image[529], 1);
    chk("paint.count", $countones(in_image), 2);
    chk("paint.ink", ink_count, 2);
    chk("paint.x", cursor_x, 17);

    // Vector table.
    step(8'h00, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].vin, 1'b0);
      chk($sformatf("tbl%0d.x", i), cursor_x, tbl[i].ex);
      chk($sformatf("tbl%0d.y", i), cursor_y, tbl[i].ey);
      chk($sformatf("tbl%0d.ink", i), ink_count, tbl[i].eink);
      chk($sformatf("tbl%0d.valid", i), image_valid, tbl[i].ev);
      chk($sformatf("tbl%0d.busy", i), busy, tbl[i].eb);
      chk_model($sformatf("tbl%0d.m", i));
    end

    // Saturation at both corners.
    step(8'h00, 1'b1);
    for (int i = 0; i < 16; i++) step(VLeft, 1'b0);
    for (int i = 0; i < 16; i++) step(VUp, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(VUp, 1'b0);
      step(VLeft, 1'b0);
    end
    chk("sat0.x", cursor_x, 0);
    chk("sat0.y", cursor_y, 0);
    for (int i = 0; i < 32; i++) step(VRight | VDown, 1'b0);
    step(VDown, 1'b0);
    chk("sat31.x", cursor_x, 31);
    chk("sat31.y", cursor_y, 31);

    // Submit with empty canvas, then a real submit; HOLD freezes the image.
    step(8'h00, 1'b1);
    step(VSub, 1'b0);
    chk("sub0.valid", image_valid, 0);
    step(VPen, 1'b0);
    step(VSub, 1'b0);
    chk("sub1.valid", image_valid, 1);
    snap = in_image;
    step(VPen | VRight, 1'b0);
    step(VPen | VDown, 1'b0);
    chk_img("hold.img", in_image, snap);
    chk("hold.x", cursor_x, 17);
    chk("hold.y", cursor_y, 17);
    chk("hold.ink", ink_count, 1);

    // Paint column x=5 on every row, hand off and watch the sweep.
    step(8'h00, 1'b1);
    for (int i = 0; i < 11; i++) step(VLeft, 1'b0);
    for (int i = 0; i < 16; i++) step(VUp, 1'b0);
    for (int i = 0; i < 32; i++) step(VPen | VDown, 1'b0);
    chk("col.ink", ink_count, 32);
    step(VSub, 1'b0);
    chk("col.valid", image_valid, 1);
    step(VAck, 1'b0);
    chk("ack.valid", image_valid, 0);
    chk("ack.busy", busy, 1);
    chk("ack.ink", ink_count, 0);
    for (int k = 1; k <= 32; k++) begin
      step(VPen | VClr | VSub | VRight, 1'b0);
      snap = in_image;
      chk($sformatf("sweep%0d.row", k), snap[(k - 1) * 32 +: 32], 0);
      if (k < 32) chk($sformatf("sweep%0d.next", k), snap[k * 32 + 5], 1);
      chk($sformatf("sweep%0d.busy", k), busy, k < 32);
    end
    chk_img("sweep.img", in_image, '0);
    chk("sweep.ink", ink_count, 0);
    chk("sweep.x", cursor_x, 5);

    // clear beats submit; reset during sweep cycle 10.
    step(8'h00, 1'b1);
    step(VPen | VRight, 1'b0);
    step(VClr | VSub, 1'b0);
    chk("clrsub.valid", image_valid, 0);
    chk("clrsub.busy", busy, 1);
    for (int i = 0; i < 9; i++) step(8'h00, 1'b0);
    step(8'h00, 1'b1);
    chk_img("midrst.img", in_image, '0);
    chk("midrst.busy", busy, 0);
    chk("midrst.x", cursor_x, 16);
    chk("midrst.y", cursor_y, 16);
    chk("midrst.ink", ink_count, 0);

    // Holding the pen on one pixel counts once.
    for (int i = 0; i < 5; i++) step(VPen, 1'b0);
    chk("pen5.ink", ink_count, 1);

    // Random traffic against the model.
    step(8'h00, 1'b1);
    for (int i = 0; i < 2000; i++) begin
      logic [7:0] v;
      v[7] = ($urandom_range(0, 3) == 0);
      v[6] = ($urandom_range(0, 3) == 0);
      v[5] = ($urandom_range(0, 3) == 0);
      v[4] = ($urandom_range(0, 3) == 0);
      v[3] = $urandom_range(0, 1);
      v[2] = ($urandom_range(0, 149) == 0);
      v[1] = ($urandom_range(0, 39) == 0);
      v[0] = ($urandom_range(0, 7) == 0);
      step(v, $urandom_range(0, 399) == 0);
      chk_model($sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
